// File: rtl/kronos_lsu_pipe_pkg.sv
// Shared types for the pipelined load/store unit: access size encoding,
// response tag layout and the alignment rules common to issue and writeback.
package kronos_lsu_pipe_pkg;

  typedef enum logic [1:0] {
    LSU_BYTE = 2'b00,
    LSU_HALF = 2'b01,
    LSU_WORD = 2'b10
  } lsu_size_t;

  typedef struct packed {
    logic      store;
    lsu_size_t size;
    logic      uns;
    logic [1:0] off;
    logic [4:0] rd;
    logic      vld;
  } lsu_tag_t;

  // Encoding 2'b11 is folded onto a word access.
  function automatic lsu_size_t decode_size(input logic [1:0] raw);
    case (raw)
      2'b00:   decode_size = LSU_BYTE;
      2'b01:   decode_size = LSU_HALF;
      default: decode_size = LSU_WORD;
    endcase
  endfunction

  function automatic logic is_misaligned(input lsu_size_t size, input logic [1:0] off);
    case (size)
      LSU_HALF: is_misaligned = off[0];
      LSU_WORD: is_misaligned = (off != 2'b00);
      default:  is_misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/kronos_load_align.sv
// Combinational load data extractor: selects the addressed byte/half lane
// and sign- or zero-extends it to 32 bits.
module kronos_load_align
  import kronos_lsu_pipe_pkg::*;
(
  input  logic [31:0] i_rd_data,
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  input  logic [1:0]  i_off,
  output logic [31:0] o_data
);

  logic [31:0] w_shift;

  assign w_shift = i_rd_data >> {i_off, 3'b000};

  always_comb begin
    o_data = i_rd_data;
    case (i_size)
      LSU_BYTE: o_data = {{24{w_shift[7] & ~i_unsigned}}, w_shift[7:0]};
      LSU_HALF: o_data = {{16{w_shift[15] & ~i_unsigned}}, w_shift[15:0]};
      default:  o_data = i_rd_data;
    endcase
  end

endmodule

// File: rtl/kronos_lsu_pipe.sv
// Pipelined load/store unit: up to DEPTH outstanding bus transactions tracked
// by an in-order tag queue, with registered writeback and misalignment report.
module kronos_lsu_pipe
  import kronos_lsu_pipe_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_vld,
  output logic        req_rdy,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic        req_store,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [4:0]  req_rd,
  output logic [31:0] data_addr,
  output logic [31:0] data_wr_data,
  output logic [3:0]  data_mask,
  output logic        data_wr_en,
  output logic        data_req,
  input  logic        data_gnt,
  input  logic        data_rvalid,
  input  logic [31:0] data_rd_data,
  output logic        regwr_en,
  output logic [4:0]  regwr_sel,
  output logic [31:0] regwr_data,
  output logic [31:0] pending_mask,
  output logic        exc_vld,
  output logic        exc_store,
  output logic [31:0] exc_addr,
  output logic        busy,
  output logic        err
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [CW-1:0] r_count;
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  lsu_tag_t      r_tags [DEPTH];

  logic          r_regwr_en;
  logic [4:0]    r_regwr_sel;
  logic [31:0]   r_regwr_data;
  logic          r_exc_vld;
  logic          r_exc_store;
  logic [31:0]   r_exc_addr;
  logic          r_err;

  lsu_size_t     w_size;
  logic          w_mis;
  logic          w_space;
  logic          w_push;
  logic          w_pop;
  logic          w_wb;
  lsu_tag_t      w_head;
  lsu_tag_t      w_new_tag;
  logic [31:0]   w_align;
  logic [31:0]   w_entry_mask [DEPTH];

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    ptr_inc = (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  assign w_size  = decode_size(req_size);
  assign w_mis   = is_misaligned(w_size, req_addr[1:0]);
  // A response arriving this cycle frees a slot for a new issue.
  assign w_space = (r_count < FULL_CNT) || data_rvalid;

  assign data_req = req_vld && !w_mis && w_space;
  assign w_push   = data_req && data_gnt;
  assign req_rdy  = w_push || (req_vld && w_mis);
  assign w_pop    = data_rvalid && (r_count != '0);

  assign data_addr  = {req_addr[31:2], 2'b00};
  assign data_wr_en = req_store;

  always_comb begin
    data_mask    = 4'b1111;
    data_wr_data = req_wdata;
    case (w_size)
      LSU_BYTE: begin
        data_mask    = 4'b0001 << req_addr[1:0];
        data_wr_data = {4{req_wdata[7:0]}};
      end
      LSU_HALF: begin
        data_mask    = 4'b0011 << req_addr[1:0];
        data_wr_data = {2{req_wdata[15:0]}};
      end
      default: begin
        data_mask    = 4'b1111;
        data_wr_data = req_wdata;
      end
    endcase
  end

  always_comb begin
    w_new_tag       = '0;
    w_new_tag.store = req_store;
    w_new_tag.size  = w_size;
    w_new_tag.uns   = req_unsigned;
    w_new_tag.off   = req_addr[1:0];
    w_new_tag.rd    = req_rd;
    w_new_tag.vld   = 1'b1;
  end

  assign w_head = r_tags[r_rd_ptr];
  assign w_wb   = w_pop && !w_head.store && (w_head.rd != 5'd0);

  kronos_load_align u_align (
    .i_rd_data  (data_rd_data),
    .i_size     (w_head.size),
    .i_unsigned (w_head.uns),
    .i_off      (w_head.off),
    .o_data     (w_align)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count      <= '0;
      r_rd_ptr     <= '0;
      r_wr_ptr     <= '0;
      for (int i = 0; i < DEPTH; i++) r_tags[i] <= '0;
      r_regwr_en   <= 1'b0;
      r_regwr_sel  <= 5'd0;
      r_regwr_data <= 32'd0;
      r_exc_vld    <= 1'b0;
      r_exc_store  <= 1'b0;
      r_exc_addr   <= 32'd0;
      r_err        <= 1'b0;
    end else begin
      if (w_push && !w_pop) r_count <= r_count + 1'b1;
      else if (w_pop && !w_push) r_count <= r_count - 1'b1;

      // Push follows pop so a full-queue refill of the same slot stays valid.
      if (w_pop) begin
        r_tags[r_rd_ptr].vld <= 1'b0;
        r_rd_ptr             <= ptr_inc(r_rd_ptr);
      end
      if (w_push) begin
        r_tags[r_wr_ptr] <= w_new_tag;
        r_wr_ptr         <= ptr_inc(r_wr_ptr);
      end

      r_regwr_en <= w_wb;
      if (w_wb) begin
        r_regwr_sel  <= w_head.rd;
        r_regwr_data <= w_align;
      end

      r_exc_vld <= req_vld && w_mis;
      if (req_vld && w_mis) begin
        r_exc_store <= req_store;
        r_exc_addr  <= req_addr;
      end

      if (data_rvalid && (r_count == '0)) r_err <= 1'b1;
    end
  end

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_pend
      assign w_entry_mask[gi] =
        (r_tags[gi].vld && !r_tags[gi].store && (r_tags[gi].rd != 5'd0))
          ? (32'd1 << r_tags[gi].rd) : 32'd0;
    end
  endgenerate

  always_comb begin
    pending_mask = r_regwr_en ? (32'd1 << r_regwr_sel) : 32'd0;
    for (int i = 0; i < DEPTH; i++) pending_mask = pending_mask | w_entry_mask[i];
  end

  assign busy       = (r_count != '0) || r_regwr_en;
  assign regwr_en   = r_regwr_en;
  assign regwr_sel  = r_regwr_sel;
  assign regwr_data = r_regwr_data;
  assign exc_vld    = r_exc_vld;
  assign exc_store  = r_exc_store;
  assign exc_addr   = r_exc_addr;
  assign err        = r_err;

endmodule

// File: tb/tb_kronos_lsu_pipe.sv
// Randomized bench for kronos_lsu_pipe against a queue-based transaction model
// of the bus, writeback, scoreboard and exception behaviour.
module tb_kronos_lsu_pipe;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_vld;
  logic        req_rdy;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_store;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [4:0]  req_rd;
  logic [31:0] data_addr;
  logic [31:0] data_wr_data;
  logic [3:0]  data_mask;
  logic        data_wr_en;
  logic        data_req;
  logic        data_gnt;
  logic        data_rvalid;
  logic [31:0] data_rd_data;
  logic        regwr_en;
  logic [4:0]  regwr_sel;
  logic [31:0] regwr_data;
  logic [31:0] pending_mask;
  logic        exc_vld;
  logic        exc_store;
  logic [31:0] exc_addr;
  logic        busy;
  logic        err;

  always #5 clk = ~clk;

  kronos_lsu_pipe #(.DEPTH(DEPTH)) u_dut (
    .clk(clk), .rst(rst),
    .req_vld(req_vld), .req_rdy(req_rdy), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_store(req_store), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_rd(req_rd),
    .data_addr(data_addr), .data_wr_data(data_wr_data), .data_mask(data_mask),
    .data_wr_en(data_wr_en), .data_req(data_req), .data_gnt(data_gnt),
    .data_rvalid(data_rvalid), .data_rd_data(data_rd_data),
    .regwr_en(regwr_en), .regwr_sel(regwr_sel), .regwr_data(regwr_data),
    .pending_mask(pending_mask), .exc_vld(exc_vld), .exc_store(exc_store),
    .exc_addr(exc_addr), .busy(busy), .err(err)
  );

  typedef struct {
    bit store;
    int size;
    bit uns;
    int off;
    int rd;
  } ent_t;

  ent_t        m_q[$];
  bit          m_wb_en;
  int          m_wb_rd;
  logic [31:0] m_wb_data;
  bit          m_exc_vld;
  bit          m_exc_store;
  logic [31:0] m_exc_addr;
  bit          m_err;

  int n_checks = 0;
  int n_errors = 0;
  int n_txn    = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic int size_class(input logic [1:0] raw);
    return (raw >= 2) ? 2 : int'(raw);
  endfunction

  function automatic bit f_mis(input int size, input logic [31:0] a);
    if (size == 1) return a[0];
    if (size == 2) return a[1:0] != 2'b00;
    return 1'b0;
  endfunction

  function automatic logic [31:0] f_align(input logic [31:0] d, input int size, input bit uns, input int off);
    logic [31:0] v;
    v = d >> (8 * off);
    if (size == 0) begin
      v = v & 32'h0000_00FF;
      if (!uns && v >= 32'h80) v = v | 32'hFFFF_FF00;
    end else if (size == 1) begin
      v = v & 32'h0000_FFFF;
      if (!uns && v >= 32'h8000) v = v | 32'hFFFF_0000;
    end else begin
      v = d;
    end
    return v;
  endfunction

  function automatic logic [31:0] f_pending();
    logic [31:0] p;
    p = m_wb_en ? (32'd1 << m_wb_rd) : 32'd0;
    foreach (m_q[i])
      if (!m_q[i].store && m_q[i].rd != 0) p = p | (32'd1 << m_q[i].rd);
    return p;
  endfunction

  task automatic idle_inputs();
    req_vld      = 1'b0;
    req_addr     = 32'd0;
    req_wdata    = 32'd0;
    req_store    = 1'b0;
    req_size     = 2'd0;
    req_unsigned = 1'b0;
    req_rd       = 5'd0;
    data_gnt     = 1'b0;
    data_rvalid  = 1'b0;
    data_rd_data = 32'd0;
  endtask

  task automatic model_clear();
    m_q.delete();
    m_wb_en     = 1'b0;
    m_wb_rd     = 0;
    m_wb_data   = 32'd0;
    m_exc_vld   = 1'b0;
    m_exc_store = 1'b0;
    m_exc_addr  = 32'd0;
    m_err       = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    idle_inputs();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    check("rst_regwr_sel", {27'd0, regwr_sel}, 32'd0);
    check("rst_regwr_data", regwr_data, 32'd0);
    check("rst_exc_store", {31'd0, exc_store}, 32'd0);
    check("rst_exc_addr", exc_addr, 32'd0);
  endtask

  // mode 0: random traffic, 1: drain responses, 2: stray response regardless
  task automatic step(input int mode);
    int          sz;
    int          off;
    bit          mis;
    bit          e_req;
    bit          e_rdy;
    logic [31:0] wd;
    logic [3:0]  e_mask;
    logic [31:0] e_wdata;
    ent_t        e;

    check("regwr_en", {31'd0, regwr_en}, {31'd0, m_wb_en});
    if (m_wb_en) begin
      check("regwr_sel", {27'd0, regwr_sel}, m_wb_rd);
      check("regwr_data", regwr_data, m_wb_data);
    end
    check("pending_mask", pending_mask, f_pending());
    check("busy", {31'd0, busy}, {31'd0, (m_q.size() != 0) || m_wb_en});
    check("err", {31'd0, err}, {31'd0, m_err});
    check("exc_vld", {31'd0, exc_vld}, {31'd0, m_exc_vld});
    if (m_exc_vld) begin
      check("exc_store", {31'd0, exc_store}, {31'd0, m_exc_store});
      check("exc_addr", exc_addr, m_exc_addr);
    end

    idle_inputs();
    if (mode == 0) begin
      req_vld      = ($urandom % 5) != 0;
      req_store    = ($urandom % 3) == 0;
      req_size     = 2'($urandom % 4);
      req_unsigned = 1'($urandom % 2);
      req_wdata    = $urandom;
      case ($urandom % 4)
        0: req_rd = 5'd0;
        1: req_rd = 5'd5;
        2: req_rd = 5'd7;
        default: req_rd = 5'($urandom % 32);
      endcase
      sz  = size_class(req_size);
      off = $urandom % 4;
      if (($urandom % 4) != 0) off = (sz == 0) ? off : (sz == 1) ? (off & 2) : 0;
      req_addr     = ($urandom & 32'hFFFF_FFFC) | 32'(off);
      data_gnt     = ($urandom % 10) < 7;
      data_rvalid  = (m_q.size() > 0) && (($urandom % 10) < 4);
      data_rd_data = $urandom;
    end else if (mode == 1) begin
      data_rvalid  = m_q.size() > 0;
      data_rd_data = $urandom;
    end else begin
      data_rvalid  = 1'b1;
      data_rd_data = $urandom;
    end

    sz    = size_class(req_size);
    off   = int'(req_addr[1:0]);
    mis   = f_mis(sz, req_addr);
    e_req = req_vld && !mis && ((m_q.size() < DEPTH) || data_rvalid);
    e_rdy = req_vld && (mis || (e_req && data_gnt));
    wd    = req_wdata;
    if (sz == 0) begin
      e_mask  = 4'(1 << off);
      e_wdata = (wd & 32'hFF) * 32'h0101_0101;
    end else if (sz == 1) begin
      e_mask  = 4'(3 << off);
      e_wdata = (wd & 32'hFFFF) * 32'h0001_0001;
    end else begin
      e_mask  = 4'hF;
      e_wdata = wd;
    end

    #1;
    check("data_req", {31'd0, data_req}, {31'd0, e_req});
    check("req_rdy", {31'd0, req_rdy}, {31'd0, e_rdy});
    if (e_req) begin
      check("data_addr", data_addr, req_addr & 32'hFFFF_FFFC);
      check("data_mask", {28'd0, data_mask}, {28'd0, e_mask});
      check("data_wr_data", data_wr_data, e_wdata);
      check("data_wr_en", {31'd0, data_wr_en}, {31'd0, req_store});
    end

    m_wb_en = 1'b0;
    if (data_rvalid) begin
      if (m_q.size() > 0) begin
        e = m_q.pop_front();
        if (!e.store && e.rd != 0) begin
          m_wb_en   = 1'b1;
          m_wb_rd   = e.rd;
          m_wb_data = f_align(data_rd_data, e.size, e.uns, e.off);
        end
      end else begin
        m_err = 1'b1;
      end
    end
    if (e_req && data_gnt) begin
      e.store = req_store;
      e.size  = sz;
      e.uns   = req_unsigned;
      e.off   = off;
      e.rd    = int'(req_rd);
      m_q.push_back(e);
      n_txn++;
      $display("txn %0d: %s addr=%08h size=%0d rd=%0d", n_txn,
               req_store ? "store" : "load ", req_addr, sz, req_rd);
    end
    m_exc_vld = req_vld && mis;
    if (m_exc_vld) begin
      m_exc_store = req_store;
      m_exc_addr  = req_addr;
    end

    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    model_clear();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_pending", pending_mask, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_regwr_en", {31'd0, regwr_en}, 32'd0);
    check("rst_exc_vld", {31'd0, exc_vld}, 32'd0);
    check("rst_exc_addr", exc_addr, 32'd0);

    for (int c = 0; c < 1500; c++) step(0);
    apply_reset();
    for (int c = 0; c < 1500; c++) step(0);

    for (int c = 0; c < 4 * DEPTH && m_q.size() > 0; c++) step(1);
    check("drained", m_q.size(), 0);
    step(0 + 1);
    step(2);
    for (int c = 0; c < 3; c++) step(1);
    check("err_sticky", {31'd0, err}, 32'd1);

    apply_reset();
    check("post_rst_err", {31'd0, err}, 32'd0);
    check("post_rst_pending", pending_mask, 32'd0);
    check("post_rst_regwr_en", {31'd0, regwr_en}, 32'd0);
    check("post_rst_busy", {31'd0, busy}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
